div_request_adapter: RTL and testbench

Request/response front end that sits directly upstream of the unsigned divider's control unit and datapath. It accepts operand pairs over a valid/ready handshake and drives the divider's start, run and operand lines. It waits for the divider's ready flag, captures the packed remainder/quotient, and presents the result over a second valid/ready handshake. It turns the divider's free-running counter interface into a one-request-at-a-time transaction port for the rest of the core.

---
 rtl/div_request_adapter.sv | 231 +++++++++++++++++++++++
 tb/tb_div_request_adapter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_request_adapter.sv
// ============================================================================
// div_request_adapter
// ----------------------------------------------------------------------------
// Purpose:
//   Request/response front end for the unsigned divider's control unit and
//   datapath. It accepts one operand pair at a time over a valid/ready
//   handshake. It then pulses the divider's start line and holds its run
//   line until the divider reports ready. After that it captures the packed
//   remainder/quotient and presents the result over a second valid/ready
//   handshake. A watchdog aborts the transaction if the divider never
//   finishes.
//
// Optional feature (compile-time macro):
//   DIV_ZERO_BYPASS_EN - when defined, a zero divisor skips the divider
//                        entirely. The result is quotient = all ones and
//                        remainder = dividend, with dz set, and it is
//                        presented one cycle after the accept.
//                        When undefined, a zero divisor runs the full
//                        sequence and only the dz flag marks it.
//
// Parameters:
//   WIDTH       operand width
//   WDOG_LIMIT  maximum RUN-state cycles before the watchdog aborts
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   request valid
//   in_ready       out  adapter can accept a request (IDLE only)
//   in_dividend    in   [WIDTH]   dividend
//   in_divisor     in   [WIDTH]   divisor
//   div_start      out  reset/load pulse to divider control (also high in reset)
//   div_run        out  run enable to divider control
//   div_dividend   out  [WIDTH]   latched dividend
//   div_divisor    out  [WIDTH]   latched divisor
//   div_rdy        in   divider ready flag
//   div_result     in   [2*WIDTH] {remainder, quotient} from the divider
//   out_valid      out  result valid (DONE state)
//   out_ready      in   consumer accepts result
//   out_quotient   out  [WIDTH]   quotient
//   out_remainder  out  [WIDTH]   remainder
//   out_dz         out  divisor was zero
//   out_err        out  watchdog abort; quotient/remainder forced to zero
// ============================================================================
module div_request_adapter #(
  parameter int WIDTH      = 32,
  parameter int WDOG_LIMIT = 2 * WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_dividend,
  input  logic [WIDTH-1:0]   in_divisor,
  output logic               div_start,
  output logic               div_run,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic               div_rdy,
  input  logic [2*WIDTH-1:0] div_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_quotient,
  output logic [WIDTH-1:0]   out_remainder,
  output logic               out_dz,
  output logic               out_err
);

  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    CAPTURE,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WDOG_W-1:0]  wdog;
  logic               accept;
  logic               bypass;
  logic               wdog_expire;
  logic               load_pulse;

  // A request is taken only in IDLE. in_ready depends on state alone, so
  // this has no path to any output within the same cycle.
  assign accept = in_valid && (state == IDLE);

  // The bypass decision uses the live divisor at the accept edge. This is
  // the same value that is latched into div_divisor.
`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = (in_divisor == '0);
`else
  assign bypass = 1'b0;
`endif

  // The watchdog has counted WDOG_LIMIT-1 earlier RUN cycles. The current
  // cycle is the last one allowed. If div_rdy is still low here, abort.
  assign wdog_expire = (state == RUN) && !div_rdy &&
                       (wdog == WDOG_W'(WDOG_LIMIT - 1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = bypass ? DONE : LOAD;
        end
      end
      LOAD: begin
        state_next = RUN;
      end
      RUN: begin
        if (div_rdy) begin
          state_next = DRAIN;
        end else if (wdog_expire) begin
          state_next = DONE;
        end
      end
      // The divider needs one more run cycle to commit its final shift.
      // During that cycle its shift control also clears.
      DRAIN: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = DONE;
      end
      // A new in_valid in DONE is ignored. It is accepted from IDLE on the
      // following cycle.
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from the current state
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready   = 1'b0;
    load_pulse = 1'b0;
    div_run    = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE:    in_ready   = 1'b1;
      LOAD:    load_pulse = 1'b1;
      RUN:     div_run    = 1'b1;
      DRAIN:   div_run    = 1'b1;
      DONE:    out_valid  = 1'b1;
      default: ;
    endcase
  end

  // The divider control is held in reset whenever the adapter is. This is a
  // deliberate combinational path from rst_n.
  assign div_start = ~rst_n | load_pulse;

  // --------------------------------------------------------------------------
  // Watchdog: counts RUN cycles and clears in every other state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if (state == RUN) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Operand and result registers
  // --------------------------------------------------------------------------
  // Operands stay stable from the accept edge through CAPTURE because they
  // change only on the next accept. The result registers change only on
  // accept (bypass), on watchdog abort, or in CAPTURE. That keeps them
  // stable for the whole time DONE waits on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_dividend  <= '0;
      div_divisor   <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dz        <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      if (accept) begin
        div_dividend <= in_dividend;
        div_divisor  <= in_divisor;
        out_dz       <= (in_divisor == '0);
        out_err      <= 1'b0;
        if (bypass) begin
          out_quotient  <= '1;
          out_remainder <= in_dividend;
        end
      end
      if (wdog_expire) begin
        out_err       <= 1'b1;
        out_quotient  <= '0;
        out_remainder <= '0;
      end
      if (state == CAPTURE) begin
        out_quotient  <= div_result[WIDTH-1:0];
        out_remainder <= div_result[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_div_request_adapter.sv
// ============================================================================
// tb_div_request_adapter
// ----------------------------------------------------------------------------
// Directed bench for div_request_adapter (WIDTH=32). A small behavioural
// divider stub stands in for the real divider. After start, it raises its
// ready flag once it has seen WIDTH+1 run cycles. The stub can be forced to
// never finish, which exercises the watchdog.
// ============================================================================
module tb_div_request_adapter;

  localparam int WIDTH = 32;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_dividend;
  logic [WIDTH-1:0]   in_divisor;
  logic               div_start;
  logic               div_run;
  logic [WIDTH-1:0]   div_dividend;
  logic [WIDTH-1:0]   div_divisor;
  logic               div_rdy;
  logic [2*WIDTH-1:0] div_result;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_quotient;
  logic [WIDTH-1:0]   out_remainder;
  logic               out_dz;
  logic               out_err;

  int compares;
  int mismatches;
  int edges;
  int run_cycles;
  int run_snap;
  logic stub_stuck;
  logic [7:0] stub_cnt;

  div_request_adapter #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .div_start     (div_start),
    .div_run       (div_run),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_rdy       (div_rdy),
    .div_result    (div_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_dz        (out_dz),
    .out_err       (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference division used by the stub: {remainder, quotient}. A zero
  // divisor yields what a restoring divider produces.
  function automatic logic [2*WIDTH-1:0] model_div(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    if (b == '0) return {a, {WIDTH{1'b1}}};
    return {a % b, a / b};
  endfunction

  // Divider stub. Start reloads it and fills the result register with a
  // junk pattern. The real value appears together with the ready flag.
  always @(posedge clk) begin
    if (div_start) begin
      stub_cnt   <= '0;
      div_rdy    <= 1'b0;
      div_result <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (div_run && !div_rdy && !stub_stuck) begin
      stub_cnt <= stub_cnt + 8'd1;
      if (stub_cnt == 8'(WIDTH)) begin
        div_rdy    <= 1'b1;
        div_result <= model_div(div_dividend, div_divisor);
      end
    end
  end

  // Counts cycles with div_run high.
  always @(posedge clk) begin
    if (div_run) run_cycles <= run_cycles + 1;
  end

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compares++;
    assert (observed === expected)
    else begin
      mismatches++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one request for exactly one accept edge. Returns right after
  // that edge, with in_valid already dropped.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid is observed, with a fixed cycle budget.
  task automatic waitOut(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) return;
    end
    n = -1;
  endtask

  initial begin
    compares    = 0;
    mismatches  = 0;
    run_cycles  = 0;
    stub_stuck  = 1'b0;
    stub_cnt    = '0;
    div_rdy     = 1'b0;
    div_result  = '0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b1;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_div_start", 64'(div_start), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_div_run", 64'(div_run), 64'd0);
    checkOutput("rst_div_start_rel", 64'(div_start), 64'd0);
    checkOutput("rst_dz_err", {62'd0, out_dz, out_err}, 64'd0);
    checkOutput("rst_q", 64'(out_quotient), 64'd0);

    // ---- 100 / 7, out_ready high
    $display("[TB] 100 / 7");
    applyStimulus(32'd100, 32'd7);
    checkOutput("load_start", 64'(div_start), 64'd1);
    checkOutput("load_in_ready", 64'(in_ready), 64'd0);
    waitOut(edges);
    checkOutput("t1_latency", 64'(edges), 64'd37);
    checkOutput("t1_q", 64'(out_quotient), 64'd14);
    checkOutput("t1_r", 64'(out_remainder), 64'd2);
    checkOutput("t1_dz_err", {62'd0, out_dz, out_err}, 64'd0);
    checkOutput("t1_in_ready_done", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("t1_valid_drop", 64'(out_valid), 64'd0);

    // ---- 0xFFFFFFFF / 1 with backpressure
    $display("[TB] 0xFFFFFFFF / 1 with out_ready low");
    out_ready = 1'b0;
    applyStimulus(32'hFFFF_FFFF, 32'd1);
    waitOut(edges);
    checkOutput("t2_latency", 64'(edges), 64'd37);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t2_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("t2_hold_q", 64'(out_quotient), 64'hFFFF_FFFF);
      checkOutput("t2_hold_r", 64'(out_remainder), 64'd0);
      checkOutput("t2_hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t2_release_valid", 64'(out_valid), 64'd0);
    checkOutput("t2_release_in_ready", 64'(in_ready), 64'd1);

    // ---- 55 / 0
    $display("[TB] 55 / 0");
    run_snap = run_cycles;
    applyStimulus(32'd55, 32'd0);
`ifdef DIV_ZERO_BYPASS_EN
    checkOutput("t3_bypass_valid", 64'(out_valid), 64'd1);
    checkOutput("t3_bypass_start", 64'(div_start), 64'd0);
    checkOutput("t3_q", 64'(out_quotient), 64'hFFFF_FFFF);
    checkOutput("t3_r", 64'(out_remainder), 64'd55);
    checkOutput("t3_dz", 64'(out_dz), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("t3_no_run", 64'(run_cycles - run_snap), 64'd0);
`else
    waitOut(edges);
    checkOutput("t3_latency", 64'(edges), 64'd37);
    checkOutput("t3_dz", 64'(out_dz), 64'd1);
    checkOutput("t3_err", 64'(out_err), 64'd0);
    @(posedge clk);
    #1;
`endif

    // ---- reset pulsed during RUN, then 9 / 4
    $display("[TB] reset during RUN");
    applyStimulus(32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_start_in_rst", 64'(div_start), 64'd1);
    checkOutput("t4_run_in_rst", 64'(div_run), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("t4_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t4_out_valid", 64'(out_valid), 64'd0);
    applyStimulus(32'd9, 32'd4);
    waitOut(edges);
    checkOutput("t4_latency", 64'(edges), 64'd37);
    checkOutput("t4_q", 64'(out_quotient), 64'd2);
    checkOutput("t4_r", 64'(out_remainder), 64'd1);
    @(posedge clk);
    #1;

    // ---- watchdog: stub never raises ready
    $display("[TB] watchdog");
    stub_stuck = 1'b1;
    applyStimulus(32'd10, 32'd5);
    waitOut(edges);
    checkOutput("t5_latency", 64'(edges), 64'd65);
    checkOutput("t5_err", 64'(out_err), 64'd1);
    checkOutput("t5_q", 64'(out_quotient), 64'd0);
    checkOutput("t5_r", 64'(out_remainder), 64'd0);
    checkOutput("t5_dz", 64'(out_dz), 64'd0);
    @(posedge clk);
    #1;
    stub_stuck = 1'b0;

    // ---- back-to-back with in_valid held high
    $display("[TB] back-to-back 20/3 then 17/17");
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = 32'd20;
    in_divisor  = 32'd3;
    @(posedge clk);
    #1;
    in_dividend = 32'd17;
    in_divisor  = 32'd17;
    waitOut(edges);
    checkOutput("t6a_latency", 64'(edges), 64'd37);
    checkOutput("t6a_q", 64'(out_quotient), 64'd6);
    checkOutput("t6a_r", 64'(out_remainder), 64'd2);
    @(posedge clk);
    #1;
    checkOutput("t6_idle_after_handshake", 64'(in_ready), 64'd1);
    checkOutput("t6_valid_low", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("t6b_accepted", 64'(in_ready), 64'd0);
    checkOutput("t6b_start", 64'(div_start), 64'd1);
    in_valid = 1'b0;
    waitOut(edges);
    checkOutput("t6b_latency", 64'(edges), 64'd37);
    checkOutput("t6b_q", 64'(out_quotient), 64'd1);
    checkOutput("t6b_r", 64'(out_remainder), 64'd0);
    checkOutput("t6b_dz_err", {62'd0, out_dz, out_err}, 64'd0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
